// File: rtl/ps2_cursor_controller.sv
// PS/2 scancode parser driving the Game of Life cursor and command pulses.
// Arrow keys move (x,y) with hardware auto-repeat; other keys act on release.
module ps2_cursor_controller #(
    parameter int GRID_W       = 40,
    parameter int GRID_H       = 30,
    parameter int X_W          = 6,
    parameter int Y_W          = 5,
    parameter int WRAP         = 0,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic [7:0]     ps2_key_data,
    input  logic           ps2_key_pressed,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           move,
    output logic           change,
    output logic           run,
    output logic           clear_board,
    output logic           load_enable,
    output logic [2:0]     load_config,
    output logic           save_enable,
    output logic           speed_up,
    output logic           speed_down
);

    localparam int T_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int T_W   = $clog2(T_MAX);
    localparam logic [T_W-1:0] T_DELAY = T_W'(REPEAT_DELAY - 1);
    localparam logic [T_W-1:0] T_RATE  = T_W'(REPEAT_RATE - 1);
    localparam logic [X_W-1:0] X_MAX   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(GRID_H - 1);
    localparam logic [1:0] DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_e;

    state_e         state_q, state_d;
    logic [3:0]     held_q, held_d;
    logic [1:0]     active_q, active_d;
    logic [T_W-1:0] timer_q, timer_d;
    logic           timer_on_q, timer_on_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           run_q, run_d;
    logic [2:0]     cfg_q, cfg_d;
    logic           move_q, move_d, change_q, change_d, clear_q, clear_d;
    logic           load_q, load_d, save_q, save_d, up_q, up_d, down_q, down_d;
    logic           step_req_s;
    logic [1:0]     step_dir_s;
    logic [1:0]     key_dir_s;

    function automatic logic is_arrow(input logic [7:0] code);
        return (code == 8'h75) || (code == 8'h72) || (code == 8'h6B) || (code == 8'h74);
    endfunction

    function automatic logic [1:0] arrow_dir(input logic [7:0] code);
        case (code)
            8'h75:   return DIR_UP;
            8'h72:   return DIR_DOWN;
            8'h6B:   return DIR_LEFT;
            default: return DIR_RIGHT;
        endcase
    endfunction

    assign key_dir_s = arrow_dir(ps2_key_data);

    // Parser, repeat timer, cursor stepping and command decode.
    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        active_d   = active_q;
        timer_d    = timer_q;
        timer_on_d = timer_on_q;
        x_d        = x_q;
        y_d        = y_q;
        run_d      = run_q;
        cfg_d      = cfg_q;
        change_d   = 1'b0;
        clear_d    = 1'b0;
        load_d     = 1'b0;
        save_d     = 1'b0;
        up_d       = 1'b0;
        down_d     = 1'b0;
        step_req_s = 1'b0;
        step_dir_s = active_q;

        if (timer_on_q) begin
            if (timer_q == T_W'(0)) begin
                if (held_q[active_q]) begin
                    step_req_s = 1'b1;
                    timer_d    = T_RATE;
                end else begin
                    timer_on_d = 1'b0;
                end
            end else begin
                timer_d = timer_q - T_W'(1);
            end
        end else begin
            timer_d = timer_q;
        end

        if (ps2_key_pressed) begin
            case (state_q)
                S_IDLE: begin
                    if (ps2_key_data == 8'hE0)      state_d = S_EXT;
                    else if (ps2_key_data == 8'hF0) state_d = S_BRK;
                    else                            state_d = S_IDLE;
                end
                S_EXT: begin
                    if (ps2_key_data == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        state_d = S_IDLE;
                        // A byte-driven step overrides any repeat expiry this cycle.
                        if (is_arrow(ps2_key_data) && !held_q[key_dir_s]) begin
                            held_d[key_dir_s] = 1'b1;
                            active_d   = key_dir_s;
                            step_req_s = 1'b1;
                            step_dir_s = key_dir_s;
                            timer_d    = T_DELAY;
                            timer_on_d = 1'b1;
                        end else begin
                            held_d = held_d;
                        end
                    end
                end
                S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (is_arrow(ps2_key_data)) begin
                        held_d[key_dir_s] = 1'b0;
                        if (key_dir_s == active_q) begin
                            timer_on_d = 1'b0;
                            step_req_s = 1'b0;
                        end else begin
                            timer_on_d = timer_on_d;
                        end
                    end else begin
                        held_d = held_d;
                    end
                end
                S_BRK: begin
                    state_d = S_IDLE;
                    case (ps2_key_data)
                        8'h29: begin change_d = 1'b1; run_d = 1'b0; end
                        8'h4D: run_d = ~run_q;
                        8'h1B: save_d = 1'b1;
                        8'h2D: begin clear_d = 1'b1; run_d = 1'b0; end
                        8'h16: begin cfg_d = 3'd0; load_d = 1'b1; run_d = 1'b0; end
                        8'h1E: begin cfg_d = 3'd1; load_d = 1'b1; run_d = 1'b0; end
                        8'h26: begin cfg_d = 3'd2; load_d = 1'b1; run_d = 1'b0; end
                        8'h25: begin cfg_d = 3'd3; load_d = 1'b1; run_d = 1'b0; end
                        8'h2E: begin cfg_d = 3'd4; load_d = 1'b1; run_d = 1'b0; end
                        8'h4B: begin cfg_d = 3'd7; load_d = 1'b1; run_d = 1'b0; end
                        8'h4E: down_d = 1'b1;
                        8'h55: up_d = 1'b1;
                        default: run_d = run_d;
                    endcase
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end

        if (step_req_s) begin
            case (step_dir_s)
                DIR_UP: begin
                    if (y_q != Y_W'(0))  y_d = y_q - Y_W'(1);
                    else if (WRAP != 0)  y_d = Y_MAX;
                    else                 y_d = y_q;
                end
                DIR_DOWN: begin
                    if (y_q != Y_MAX)    y_d = y_q + Y_W'(1);
                    else if (WRAP != 0)  y_d = Y_W'(0);
                    else                 y_d = y_q;
                end
                DIR_LEFT: begin
                    if (x_q != X_W'(0))  x_d = x_q - X_W'(1);
                    else if (WRAP != 0)  x_d = X_MAX;
                    else                 x_d = x_q;
                end
                default: begin
                    if (x_q != X_MAX)    x_d = x_q + X_W'(1);
                    else if (WRAP != 0)  x_d = X_W'(0);
                    else                 x_d = x_q;
                end
            endcase
        end else begin
            x_d = x_q;
        end

        move_d = (x_d != x_q) || (y_d != y_q);
        if (move_d) run_d = 1'b0;
        else        run_d = run_d;
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            held_q     <= 4'd0;
            active_q   <= 2'd0;
            timer_q    <= T_W'(0);
            timer_on_q <= 1'b0;
            x_q        <= X_W'(0);
            y_q        <= Y_W'(0);
            run_q      <= 1'b0;
            cfg_q      <= 3'd0;
            move_q     <= 1'b0;
            change_q   <= 1'b0;
            clear_q    <= 1'b0;
            load_q     <= 1'b0;
            save_q     <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            active_q   <= active_d;
            timer_q    <= timer_d;
            timer_on_q <= timer_on_d;
            x_q        <= x_d;
            y_q        <= y_d;
            run_q      <= run_d;
            cfg_q      <= cfg_d;
            move_q     <= move_d;
            change_q   <= change_d;
            clear_q    <= clear_d;
            load_q     <= load_d;
            save_q     <= save_d;
            up_q       <= up_d;
            down_q     <= down_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign move        = move_q;
    assign change      = change_q;
    assign run         = run_q;
    assign clear_board = clear_q;
    assign load_enable = load_q;
    assign load_config = cfg_q;
    assign save_enable = save_q;
    assign speed_up    = up_q;
    assign speed_down  = down_q;

endmodule

// File: tb/tb_ps2_cursor_controller.sv
// Scoreboard bench for ps2_cursor_controller: expected output events are queued
// with their due cycle and a negedge monitor pops and compares them.
module tb_ps2_cursor_controller;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic [7:0] kd = 8'h00;
    logic kp = 1'b0;

    logic [5:0] x0, x1;
    logic [4:0] y0, y1;
    logic mv0, ch0, run0, clr0, ld0, sv0, up0, dn0;
    logic mv1, ch1, run1, clr1, ld1, sv1, up1, dn1;
    logic [2:0] cfg0, cfg1;

    ps2_cursor_controller #(.WRAP(0), .REPEAT_DELAY(20), .REPEAT_RATE(8)) dut0 (
        .clock(clock), .resetn(resetn), .ps2_key_data(kd), .ps2_key_pressed(kp),
        .x(x0), .y(y0), .move(mv0), .change(ch0), .run(run0), .clear_board(clr0),
        .load_enable(ld0), .load_config(cfg0), .save_enable(sv0),
        .speed_up(up0), .speed_down(dn0));

    ps2_cursor_controller #(.WRAP(1), .REPEAT_DELAY(20), .REPEAT_RATE(8)) dut1 (
        .clock(clock), .resetn(resetn), .ps2_key_data(kd), .ps2_key_pressed(kp),
        .x(x1), .y(y1), .move(mv1), .change(ch1), .run(run1), .clear_board(clr1),
        .load_enable(ld1), .load_config(cfg1), .save_enable(sv1),
        .speed_up(up1), .speed_down(dn1));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int c; logic [21:0] v; } exp_t;
    typedef struct { string name; int act; int exp; } chk_t;
    exp_t q[$];
    chk_t dq[$];
    exp_t e;
    chk_t d;
    int n_cmp = 0;
    int n_bad = 0;
    int mv1_cnt = 0;
    int t_drv = 0;

    logic [5:0] ex_x = 6'd0;
    logic [4:0] ex_y = 5'd0;
    logic ex_run = 1'b0;
    logic [2:0] ex_cfg = 3'd0;
    logic [21:0] act_v;

    assign act_v = {x0, y0, mv0, ch0, run0, clr0, ld0, cfg0, sv0, up0, dn0};

    // Monitor: compare every output event against the scoreboard, then drain level checks.
    always @(negedge clock) begin
        if (resetn && (mv0 | ch0 | clr0 | ld0 | sv0 | up0 | dn0)) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: actual cyc=%0d val=%h required=none", cyc, act_v);
            end else begin
                e = q.pop_front();
                if (e.c != cyc || e.v != act_v) begin
                    n_bad++;
                    $display("FAIL event: actual cyc=%0d val=%h required cyc=%0d val=%h",
                             cyc, act_v, e.c, e.v);
                end
            end
        end
        while (dq.size() > 0) begin
            d = dq.pop_front();
            n_cmp++;
            if (d.act != d.exp) begin
                n_bad++;
                $display("FAIL %s: actual=%0d required=%0d", d.name, d.act, d.exp);
            end
        end
    end

    always @(negedge clock) if (resetn && mv1) mv1_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string n, input int a, input int x);
        dq.push_back('{n, a, x});
    endtask

    task automatic push_ev(input int c, input logic mv, input logic ch, input logic clr,
                           input logic ld, input logic sv, input logic up, input logic dn);
        q.push_back('{c, {ex_x, ex_y, mv, ch, ex_run, clr, ld, ex_cfg, sv, up, dn}});
    endtask

    task automatic drive(input logic [7:0] b);
        @(negedge clock);
        kd = b;
        kp = 1'b1;
        t_drv = cyc;
    endtask

    task automatic rel();
        @(negedge clock);
        kp = 1'b0;
        kd = 8'h00;
    endtask

    task automatic send(input logic [7:0] b);
        drive(b);
        rel();
    endtask

    task automatic arrow_tap(input logic [7:0] code);
        send(8'hE0);
        drive(code);
        if (code == 8'h74 && ex_x != 6'd39) begin
            ex_x = ex_x + 6'd1;
            ex_run = 1'b0;
            push_ev(t_drv + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else if (code == 8'h72 && ex_y != 5'd29) begin
            ex_y = ex_y + 5'd1;
            ex_run = 1'b0;
            push_ev(t_drv + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            ex_x = ex_x;
        end
        rel();
        send(8'hE0);
        send(8'hF0);
        send(code);
    endtask

    task automatic cmd_load(input logic [7:0] code, input logic [2:0] cfg);
        send(8'hF0);
        drive(code);
        ex_cfg = cfg;
        ex_run = 1'b0;
        push_ev(t_drv + 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rel();
    endtask

    int c0;

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_x", x0, 0);
        chk("reset_y", y0, 0);
        chk("reset_run", run0, 0);
        chk("reset_cfg", cfg0, 0);
        chk("reset_pulses", {mv0, ch0, clr0, ld0, sv0, up0, dn0}, 0);
        @(negedge clock);
        resetn = 1'b1;

        // Edge behaviour: run set, walk to x=39, then one more right.
        send(8'hF0); send(8'h4D);
        ex_run = 1'b1;
        chk("run_set", run0, 1);
        for (int i = 0; i < 39; i++) arrow_tap(8'h74);
        chk("x_at_39", x0, 39);
        send(8'hF0); send(8'h4D);
        ex_run = 1'b1;
        arrow_tap(8'h74);
        @(negedge clock);
        chk("clamp_x", x0, 39);
        chk("clamp_run_kept", run0, 1);
        chk("wrap_x", x1, 0);
        chk("wrap_run", run1, 0);
        chk("wrap_moves", mv1_cnt, 40);

        // Auto-repeat cadence from y=5 with typematic re-makes in between.
        for (int i = 0; i < 5; i++) arrow_tap(8'h72);
        chk("y_at_5", y0, 5);
        send(8'hE0);
        drive(8'h75);
        c0 = t_drv;
        ex_y = 5'd4; ex_run = 1'b0;
        push_ev(c0 + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex_y = 5'd3;
        push_ev(c0 + 21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex_y = 5'd2;
        push_ev(c0 + 29, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rel();
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'h75);
        while (cyc < c0 + 30) @(negedge clock);
        send(8'hE0); send(8'hF0); send(8'h75);
        repeat (40) @(negedge clock);
        chk("y_after_release", y0, 2);

        // Commands on break codes.
        cmd_load(8'h26, 3'd2);
        chk("cfg_2", cfg0, 2);
        cmd_load(8'h4B, 3'd7);
        chk("cfg_7", cfg0, 7);
        send(8'h26);
        repeat (3) @(negedge clock);
        chk("make_ignored_cfg", cfg0, 7);
        send(8'hF0); send(8'h4D);
        chk("run_toggle_1", run0, 1);
        send(8'hF0); send(8'h4D);
        chk("run_toggle_0", run0, 0);
        send(8'hF0); send(8'h4D);
        send(8'hF0);
        drive(8'h29);
        ex_run = 1'b0;
        push_ev(t_drv + 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rel();
        chk("change_run", run0, 0);
        send(8'hF0);
        drive(8'h1B);
        push_ev(t_drv + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rel();
        send(8'hF0);
        drive(8'h2D);
        push_ev(t_drv + 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rel();
        send(8'hF0);
        drive(8'h4E);
        push_ev(t_drv + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rel();
        send(8'hF0);
        drive(8'h55);
        push_ev(t_drv + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rel();
        send(8'h74); send(8'hF0); send(8'h74);
        repeat (3) @(negedge clock);
        chk("keypad_ignored_x", x0, 39);

        // Reset after E0: the following 74 must parse as a plain make.
        send(8'hE0);
        @(negedge clock); resetn = 1'b0;
        @(negedge clock); resetn = 1'b1;
        ex_x = 6'd0; ex_y = 5'd0; ex_run = 1'b0; ex_cfg = 3'd0;
        send(8'h74);
        repeat (3) @(negedge clock);
        chk("reset_mid_x", x0, 0);
        arrow_tap(8'h74);
        chk("after_reset_step_x", x0, 1);

        repeat (5) @(negedge clock);
        chk("scoreboard_empty", q.size(), 0);
        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
